// File: rtl/btb_update_scheduler.sv
// Single-port BTB owner: arbitrates IF prediction lookups against queued EX training
// updates (read-modify-write, 2-bit counters) and invalidates the table after reset.
module btb_update_scheduler #(
    parameter  int INDEX_BITS = 4,
    parameter  int FIFO_DEPTH = 4,
    parameter  int AGE_MAX    = 8,
    localparam int W          = 63 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_advance,
    input  logic                  update_btb_ex,
    input  logic                  ex_branch_taken,
    input  logic [31:0]           pc_ex,
    input  logic [31:0]           jump_addr_ex,
    input  logic                  if_lookup_req,
    input  logic [31:0]           if_pc,
    output logic                  if_grant,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    output logic                  btb_en,
    output logic                  btb_we,
    output logic [INDEX_BITS-1:0] btb_addr,
    output logic [W-1:0]          btb_wdata,
    input  logic [W-1:0]          btb_rdata,
    output logic                  fifo_full,
    output logic                  init_busy,
    output logic                  overflow_err
);
    localparam int TAG_W = 30 - INDEX_BITS;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_WR} state_t;

    state_t                 state_q, state_d;
    logic [INDEX_BITS-1:0]  init_cnt_q;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full_q;
    logic [AGE_W-1:0]       age_q, age_d;
    logic                   overflow_q;
    logic [W-1:0]           rd_entry_q;
    logic                   pred_valid_q;
    logic [TAG_W-1:0]       lk_tag_q;

    logic [31:2]            fifo_pc  [FIFO_DEPTH];
    logic [31:2]            fifo_tgt [FIFO_DEPTH];
    logic                   fifo_tk  [FIFO_DEPTH];

    logic                   push_req, push_ok, pop, full_now, fifo_empty;
    logic                   upd_wins, upd_gets_port, needs_port, wr_needed;
    logic [31:2]            head_pc, head_tgt;
    logic                   head_tk;
    logic [INDEX_BITS-1:0]  head_idx;
    logic [TAG_W-1:0]       head_tag;
    logic [W-1:0]           new_entry;
    logic                   lk_hit;
    logic                   unused_bits;

    assign unused_bits = ^{pc_ex[1:0], jump_addr_ex[1:0], if_pc[1:0]};

    // ---------------- update queue ----------------
    assign full_now   = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_req   = update_btb_ex && ex_advance;
    assign push_ok    = push_req && (!full_now || pop);

    assign head_pc  = fifo_pc[rd_ptr_q];
    assign head_tgt = fifo_tgt[rd_ptr_q];
    assign head_tk  = fifo_tk[rd_ptr_q];
    assign head_idx = head_pc[INDEX_BITS+1:2];
    assign head_tag = head_pc[31:INDEX_BITS+2];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_pc[wr_ptr_q]  <= pc_ex[31:2];
            fifo_tgt[wr_ptr_q] <= jump_addr_ex[31:2];
            fifo_tk[wr_ptr_q]  <= ex_branch_taken;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)
            count_d = count_q + 1'b1;
        else if (!push_ok && pop)
            count_d = count_q - 1'b1;
    end

    // ---------------- read-modify-write of the captured entry ----------------
    always_comb begin
        logic             old_valid, hit;
        logic [TAG_W-1:0] old_tag;
        logic [1:0]       ctr;
        old_valid = rd_entry_q[W-1];
        old_tag   = rd_entry_q[W-2 -: TAG_W];
        ctr       = rd_entry_q[1:0];
        hit       = old_valid && (old_tag == head_tag);
        new_entry = '0;
        wr_needed = 1'b0;
        if (head_tk) begin
            wr_needed = 1'b1;
            if (hit)
                ctr = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
            else
                ctr = 2'b10;
            new_entry = {1'b1, head_tag, head_tgt, ctr};
        end else if (hit) begin
            wr_needed = 1'b1;
            ctr       = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
            new_entry = {1'b1, old_tag, rd_entry_q[31:2], ctr};
        end
    end

    // ---------------- arbitration ----------------
    assign upd_wins   = !if_lookup_req || full_q || (age_q >= AGE_W'(AGE_MAX));
    assign needs_port = ((state_q == S_IDLE) && !fifo_empty) || ((state_q == S_WR) && wr_needed);

    always_comb begin
        age_d = age_q;
        if (upd_gets_port)
            age_d = '0;
        else if (needs_port && (age_q < AGE_W'(AGE_MAX)))
            age_d = age_q + 1'b1;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            init_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            age_q        <= '0;
            overflow_q   <= 1'b0;
            rd_entry_q   <= '0;
            pred_valid_q <= 1'b0;
            lk_tag_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT)
                init_cnt_q <= init_cnt_q + 1'b1;
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
            age_q   <= age_d;
            if (push_req && full_now && !pop)
                overflow_q <= 1'b1;
            if (state_q == S_RD)
                rd_entry_q <= btb_rdata;
            pred_valid_q <= if_grant;
            if (if_grant)
                lk_tag_q <= if_pc[31:INDEX_BITS+2];
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: if (init_cnt_q == '1) state_d = S_IDLE;
            S_IDLE: if (!fifo_empty && upd_wins) state_d = S_RD;
            S_RD:   state_d = S_WR;
            S_WR:   if (pop) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // ---------------- FSM: outputs / port mux ----------------
    always_comb begin
        btb_en        = 1'b0;
        btb_we        = 1'b0;
        btb_addr      = if_pc[INDEX_BITS+1:2];
        btb_wdata     = '0;
        if_grant      = 1'b0;
        pop           = 1'b0;
        upd_gets_port = 1'b0;
        case (state_q)
            S_INIT: begin
                btb_en   = 1'b1;
                btb_we   = 1'b1;
                btb_addr = init_cnt_q;
            end
            S_IDLE: begin
                if (!fifo_empty && upd_wins) begin
                    btb_en        = 1'b1;
                    btb_addr      = head_idx;
                    upd_gets_port = 1'b1;
                end else begin
                    if_grant = if_lookup_req;
                end
            end
            S_RD: if_grant = if_lookup_req;
            S_WR: begin
                if (!wr_needed) begin
                    pop      = 1'b1;
                    if_grant = if_lookup_req;
                end else if (upd_wins) begin
                    btb_en        = 1'b1;
                    btb_we        = 1'b1;
                    btb_addr      = head_idx;
                    btb_wdata     = new_entry;
                    pop           = 1'b1;
                    upd_gets_port = 1'b1;
                end else begin
                    if_grant = if_lookup_req;
                end
            end
            default: ;
        endcase
        if (if_grant)
            btb_en = 1'b1;
    end

    // Prediction is qualified by the registered grant; the RAM's own output register
    // carries the entry, so nothing is added to the lookup latency.
    assign lk_hit       = btb_rdata[W-1] && (btb_rdata[W-2 -: TAG_W] == lk_tag_q);
    assign pred_valid   = pred_valid_q;
    assign pred_taken   = pred_valid_q && lk_hit && btb_rdata[1];
    assign pred_target  = (pred_valid_q && lk_hit) ? {btb_rdata[31:2], 2'b00} : 32'h0;
    assign fifo_full    = full_q;
    assign init_busy    = (state_q == S_INIT);
    assign overflow_err = overflow_q;

endmodule
